cbp_multicycle_adder: RTL and testbench
=======================================

Name: cbp_multicycle_adder

Overview:
- Multi-cycle wide adder that time-multiplexes one instance of the team's carry-bypass adder stage (CarryBypassAdderStage, NUM_BITS = STAGE_BITS) across a WIDTH-bit operand.
- It processes one STAGE_BITS slice per clock, LSB slice first. The slice carry-out is registered and fed back as the next slice's carry-in.
- Sits directly upstream of the stage: it slices the operands, feeds the stage, and consumes the stage's Sum and Cout.
- Valid/ready handshakes on both sides let it sit between the operand source and the result consumer.

Parameters:
- WIDTH, 32, total operand width in bits. Must be a multiple of STAGE_BITS; otherwise the build must fail at elaboration.
- STAGE_BITS, 4, slice width, passed as NUM_BITS to the adder stage.
- Derived, not overridable: NUM_SLICES = WIDTH/STAGE_BITS. The slice counter is clog2(NUM_SLICES) bits, minimum 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand source has a request
- in_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to slice 0
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  registered result
- cout  out  1  carry-out of the MSB slice
- overflow  out  1  two's-complement signed overflow

Behaviour:
- States: IDLE, RUN, DONE. in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state only.
- Reset (rst = 1 at an edge, any state including mid-RUN):
  - state goes to IDLE.
  - sum, cout, overflow, the working sum, the carry register and the slice index all clear to 0.
  - Any in-flight operation is discarded.
  - Outputs after reset: in_ready = 1, out_valid = 0.
- IDLE:
  - On in_valid & in_ready: latch a, b into operand registers, carry_reg <= cin, idx <= 0, go to RUN.
  - Otherwise hold.
- RUN, each cycle:
  - The stage sees A = a_reg[idx*STAGE_BITS +: STAGE_BITS], the same slice of b_reg, and Cin = carry_reg.
  - At the edge: the working sum slice idx <= stage Sum; carry_reg <= stage Cout; idx <= idx+1.
  - When idx == NUM_SLICES-1 at the edge, instead:
    - sum <= completed working value, including the final slice.
    - cout <= stage Cout.
    - overflow <= a_reg[MSB] ^ b_reg[MSB] ^ final_sum[MSB] ^ stage Cout, i.e. carry-into-MSB xor carry-out.
    - idx <= 0; go to DONE.
- DONE:
  - sum, cout and overflow hold stable while out_valid = 1.
  - On out_ready, go to IDLE.
  - in_valid is ignored in DONE and RUN; there is no overlap of operations.
- Latency:
  - out_valid rises exactly NUM_SLICES cycles after the accepting edge (8 cycles for the defaults).
  - Back-to-back throughput is one result per NUM_SLICES+2 cycles when out_ready is held at 1.
- Output result registers change only on the RUN→DONE transition or on reset. Between operations they keep the last completed result, so out_valid alone qualifies them.
- Input changes on a, b and cin after acceptance have no effect on the result.
- Combinational rule: out_ready has no combinational path to in_ready. in_ready rises the cycle after the output handshake.
- Bypass correctness: when all bits of a slice propagate, the slice Cout equals that slice's Cin. This must hold through carry_reg across slices.

Test Plan (defaults WIDTH=32, STAGE_BITS=4):
1. a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, overflow=0; out_valid high exactly 8 cycles after the accept edge.
2. a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, overflow=1.
3. a=0x12345678, b=0x9ABCDEF0, cin=1 → sum=0xACF13569, cout=0, overflow=0. Then change a/b during RUN → result unchanged.
4. a=0xAAAAAAAA, b=0x55555555, cin=1 (every slice full-propagate) → sum=0x00000000, cout=1, overflow=0.
5. Backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
   - Required: out_valid stays 1, sum/cout are stable, in_ready=0. After out_ready=1, in_ready=1 on the next cycle and the new request is accepted there.
6. Reset mid-operation:
   - Stimulus: assert rst for 1 cycle while idx=3 in RUN.
   - Required: next cycle in_ready=1, out_valid=0, sum=0, cout=0, overflow=0. A following request with a=0x00000003, b=0x00000005 returns sum=0x00000008, cout=0.

Source files
------------

// File: rtl/cbp_multicycle_adder.sv
// rtl/cbp_multicycle_adder.sv - multi-cycle WIDTH-bit adder time-sharing one carry-bypass stage
// Slices are processed LSB first; the slice carry-out is registered and feeds the next slice.

module CarryBypassAdderStage #(
    parameter int NUM_BITS = 4
) (
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    input  logic                Cin,
    output logic [NUM_BITS-1:0] Sum,
    output logic                Cout
);
    logic [NUM_BITS:0]   c;
    logic [NUM_BITS-1:0] p;

    always_comb begin
        c    = '0;
        p    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int i = 0; i < NUM_BITS; i++) begin
            p[i]   = A[i] ^ B[i];
            Sum[i] = p[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (p[i] & c[i]);
        end
        // A fully propagating slice hands its carry-in straight through.
        Cout = (&p) ? Cin : c[NUM_BITS];
    end
endmodule

module cbp_multicycle_adder #(
    parameter int WIDTH      = 32,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NUM_SLICES = WIDTH / STAGE_BITS;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    generate
        if ((WIDTH % STAGE_BITS) != 0 || WIDTH < STAGE_BITS) begin : g_bad_width
            $error("cbp_multicycle_adder: WIDTH must be a non-zero multiple of STAGE_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, work_q, work_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q, cout_q, overflow_q;
    logic [IDX_W-1:0] idx_q;

    logic [STAGE_BITS-1:0] stage_a, stage_b, stage_sum;
    logic                  stage_cout;

    assign stage_a = a_q[idx_q*STAGE_BITS +: STAGE_BITS];
    assign stage_b = b_q[idx_q*STAGE_BITS +: STAGE_BITS];

    CarryBypassAdderStage #(.NUM_BITS(STAGE_BITS)) u_stage (
        .A    (stage_a),
        .B    (stage_b),
        .Cin  (carry_q),
        .Sum  (stage_sum),
        .Cout (stage_cout)
    );

    // Working value with the current slice merged in; on the last slice this is the full sum.
    always_comb begin
        work_d = work_q;
        work_d[idx_q*STAGE_BITS +: STAGE_BITS] = stage_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    work_q  <= work_d;
                    carry_q <= stage_cout;
                    if (idx_q == LAST_IDX) begin
                        sum_q      <= work_d;
                        cout_q     <= stage_cout;
                        overflow_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ work_d[WIDTH-1] ^ stage_cout;
                        idx_q      <= '0;
                        state_q    <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_cbp_multicycle_adder.sv
// tb/tb_cbp_multicycle_adder.sv - directed-vector bench for cbp_multicycle_adder

module tb_cbp_multicycle_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cbp_multicycle_adder #(.WIDTH(32), .STAGE_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        bit          scramble;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) check({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
    endtask

    // Returns the number of edges after the current edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input vec_t v, input string name);
        int lat;
        wait_ready(name);
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (v.scramble) begin
            a = ~v.a; b = v.b ^ 32'h5A5A_A5A5; cin = ~v.cin;
        end
        wait_valid(lat);
        check({name, "_latency"}, 64'(lat), 64'd8);
        check({name, "_sum"}, 64'(sum), 64'(v.sum));
        check({name, "_cout"}, 64'(cout), 64'(v.cout));
        check({name, "_ovf"}, 64'(overflow), 64'(v.ovf));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v;
        int lat;
        int period;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held while a new request waits.
        v = '{32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0};
        wait_ready("bp");
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h0000_0001; b = 32'h0000_0002; cin = 1'b0;
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd8);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_sum_stable", 64'(sum), 64'h30);
            check("bp_cout_stable", 64'(cout), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_ready_next", 64'(in_ready), 64'd1);
        check("bp_valid_dropped", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", 64'(in_ready), 64'd0);
        wait_valid(lat);
        check("bp_new_latency", 64'(lat), 64'd8);
        check("bp_new_sum", 64'(sum), 64'h3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset while idx == 3 in RUN.
        wait_ready("rst");
        a = 32'hDEAD_BEEF; b = 32'h0123_4567; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_sum", 64'(sum), 64'd0);
        check("rst_mid_cout", 64'(cout), 64'd0);
        check("rst_mid_ovf", 64'(overflow), 64'd0);
        v = '{32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        do_op(v, "after_rst");

        // Back-to-back throughput with both handshakes held high.
        a = 32'h0000_0001; b = 32'h0000_0001; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        wait_valid(lat);
        check("b2b_first_valid", 64'(out_valid), 64'd1);
        period = 0;
        @(posedge clk); #1; period++;
        while (out_valid !== 1'b1 && period < 30) begin
            @(posedge clk); #1;
            period++;
        end
        check("b2b_period", 64'(period), 64'd10);
        check("b2b_sum", 64'(sum), 64'h2);
        in_valid = 1'b0; out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
